// File: rtl/noc_pkg.sv
// NoC packet layout, classification constants and the filter receiver state
// type shared by the filter receive path.
package noc_pkg;

    localparam int PKT_W    = 32;
    localparam int RSVD_BIT = 31;
    localparam int TYPE_LSB = 29;
    localparam int TYPE_W   = 2;
    localparam int DST_LSB  = 21;
    localparam int DST_W    = 8;
    localparam int IDX_LSB  = 13;
    localparam int IDX_W    = 8;
    localparam int DATA_LSB = 0;
    localparam int DATA_W   = 13;

    localparam logic [TYPE_W-1:0] PKT_TYPE_FILTER = 2'b00;

    typedef struct packed {
        logic              rsvd;
        logic [TYPE_W-1:0] pkt_type;
        logic [DST_W-1:0]  dst;
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] data;
    } noc_pkt_t;

    typedef enum logic {
        ST_LOAD  = 1'b0,
        ST_DRAIN = 1'b1
    } rx_state_e;

    function automatic noc_pkt_t unpack_pkt(input logic [PKT_W-1:0] raw);
        noc_pkt_t p;
        p.rsvd     = raw[RSVD_BIT];
        p.pkt_type = raw[TYPE_LSB +: TYPE_W];
        p.dst      = raw[DST_LSB +: DST_W];
        p.idx      = raw[IDX_LSB +: IDX_W];
        p.data     = raw[DATA_LSB +: DATA_W];
        return p;
    endfunction

endpackage

// File: rtl/filter_pkt_decode.sv
// Combinational unpack and hit/err classification of an inbound NoC packet.
// Header checking (type/dst) is compiled in only with PE_FILTER_RX_PKT_CHECK_EN.
module filter_pkt_decode
    import noc_pkg::*;
#(
    parameter int         WIDTH_F = 5,
    parameter logic [7:0] PE_ADDR = 8'd0
) (
    input  logic [PKT_W-1:0]  pkt_data,
    output logic [2:0]        pkt_idx,
    output logic [DATA_W-1:0] pkt_payload,
    output logic              hit,
    output logic              err
);

    localparam logic [IDX_W-1:0] IDX_LIMIT = IDX_W'(WIDTH_F);

    noc_pkt_t pkt;
    logic     idx_ok;

    always_comb begin
        pkt         = unpack_pkt(pkt_data);
        idx_ok      = (pkt.idx < IDX_LIMIT);
        pkt_idx     = pkt.idx[2:0];
        pkt_payload = pkt.data;
    end

`ifdef PE_FILTER_RX_PKT_CHECK_EN
    logic hdr_ok;
    assign hdr_ok = (pkt.pkt_type == PKT_TYPE_FILTER) && (pkt.dst == PE_ADDR);
    assign hit    = idx_ok && hdr_ok;
    assign err    = !hit;
`else
    // Header fields are ignored; out-of-range indices are dropped silently.
    assign hit = idx_ok;
    assign err = 1'b0;
`endif

endmodule

// File: rtl/pe_filter_rx.sv
// PE filter-row receiver: collects WIDTH_F weights from NoC packets, then drains
// them in index order to the MAC. Packet checking via PE_FILTER_RX_PKT_CHECK_EN.
module pe_filter_rx
    import noc_pkg::*;
#(
    parameter int         WIDTH_DATA = 13,
    parameter int         WIDTH_F    = 5,
    parameter logic [7:0] PE_ADDR    = 8'd0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pkt_valid,
    output logic                  pkt_ready,
    input  logic [PKT_W-1:0]      pkt_data,
    output logic                  w_valid,
    input  logic                  w_ready,
    output logic [WIDTH_DATA-1:0] w_data,
    output logic [2:0]            w_idx,
    output logic                  row_loaded,
    output logic [7:0]            row_cnt,
    output logic                  err_pulse
);

    localparam logic [2:0]         K_LAST    = 3'(WIDTH_F - 1);
    localparam logic [WIDTH_F-1:0] MASK_FULL = '1;

    rx_state_e             state_reg, state_next;
    logic [WIDTH_F-1:0]    mask_reg, mask_next;
    logic [WIDTH_F-1:0]    wr_sel;
    logic [WIDTH_DATA-1:0] wbuf_reg [WIDTH_F];
    logic [2:0]            k_reg, k_next;
    logic [7:0]            row_cnt_reg, row_cnt_next;
    logic                  row_loaded_reg, row_loaded_next;
    logic                  err_pulse_reg, err_pulse_next;

    logic [2:0]            dec_idx;
    logic [DATA_W-1:0]     dec_payload;
    logic                  dec_hit;
    logic                  dec_err;
    logic [WIDTH_DATA-1:0] wr_value;
    logic                  pkt_fire;
    logic                  wr_en;
    logic                  w_fire;

    filter_pkt_decode #(
        .WIDTH_F (WIDTH_F),
        .PE_ADDR (PE_ADDR)
    ) u_decode (
        .pkt_data    (pkt_data),
        .pkt_idx     (dec_idx),
        .pkt_payload (dec_payload),
        .hit         (dec_hit),
        .err         (dec_err)
    );

    generate
        if (WIDTH_DATA > DATA_W) begin : g_pad
            assign wr_value = {{(WIDTH_DATA - DATA_W){1'b0}}, dec_payload};
        end else if (WIDTH_DATA == DATA_W) begin : g_same
            assign wr_value = dec_payload;
        end else begin : g_trunc
            assign wr_value = dec_payload[WIDTH_DATA-1:0];
        end
    endgenerate

    // One-hot write select shared by the buffer and the fill mask.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH_F; gi++) begin : g_sel
            assign wr_sel[gi] = wr_en && (dec_idx == 3'(gi));
        end
    endgenerate

    // Reset gates pkt_ready so nothing is accepted while rst_n is low.
    assign pkt_ready = rst_n && (state_reg == ST_LOAD);
    assign pkt_fire  = pkt_valid && pkt_ready;
    assign wr_en     = pkt_fire && dec_hit;
    assign w_valid   = (state_reg == ST_DRAIN);
    assign w_fire    = w_valid && w_ready;

    always_comb begin
        state_next      = state_reg;
        mask_next       = mask_reg;
        k_next          = k_reg;
        row_cnt_next    = row_cnt_reg;
        row_loaded_next = 1'b0;
        err_pulse_next  = pkt_fire && dec_err;
        case (state_reg)
            ST_LOAD: begin
                mask_next = mask_reg | wr_sel;
                if (mask_next == MASK_FULL) begin
                    state_next      = ST_DRAIN;
                    row_loaded_next = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (w_fire) begin
                    if (k_reg == K_LAST) begin
                        k_next       = 3'd0;
                        mask_next    = '0;
                        row_cnt_next = row_cnt_reg + 8'd1;
                        state_next   = ST_LOAD;
                    end else begin
                        k_next = k_reg + 3'd1;
                    end
                end
            end
            default: state_next = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= ST_LOAD;
            mask_reg       <= '0;
            k_reg          <= 3'd0;
            row_cnt_reg    <= 8'd0;
            row_loaded_reg <= 1'b0;
            err_pulse_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            mask_reg       <= mask_next;
            k_reg          <= k_next;
            row_cnt_reg    <= row_cnt_next;
            row_loaded_reg <= row_loaded_next;
            err_pulse_reg  <= err_pulse_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < WIDTH_F; i++) begin
                wbuf_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH_F; i++) begin
                if (wr_sel[i]) begin
                    wbuf_reg[i] <= wr_value;
                end
            end
        end
    end

    assign w_data     = wbuf_reg[k_reg];
    assign w_idx      = k_reg;
    assign row_loaded = row_loaded_reg;
    assign row_cnt    = row_cnt_reg;
    assign err_pulse  = err_pulse_reg;

endmodule

// File: tb/tb_pe_filter_rx.sv
// Scoreboard bench for pe_filter_rx: directed packet sequences push expected
// weights, a negedge monitor pops and compares every weight handshake.
module tb_pe_filter_rx;

    localparam int         WD   = 13;
    localparam int         WF   = 5;
    localparam logic [7:0] ADDR = 8'h2A;
`ifdef PE_FILTER_RX_PKT_CHECK_EN
    localparam int EXP_ERR = 1;
`else
    localparam int EXP_ERR = 0;
`endif

    logic          clk;
    logic          rst_n;
    logic          pkt_valid;
    logic          pkt_ready;
    logic [31:0]   pkt_data;
    logic          w_valid;
    logic          w_ready;
    logic [WD-1:0] w_data;
    logic [2:0]    w_idx;
    logic          row_loaded;
    logic [7:0]    row_cnt;
    logic          err_pulse;

    pe_filter_rx #(
        .WIDTH_DATA (WD),
        .WIDTH_F    (WF),
        .PE_ADDR    (ADDR)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pkt_valid  (pkt_valid),
        .pkt_ready  (pkt_ready),
        .pkt_data   (pkt_data),
        .w_valid    (w_valid),
        .w_ready    (w_ready),
        .w_data     (w_data),
        .w_idx      (w_idx),
        .row_loaded (row_loaded),
        .row_cnt    (row_cnt),
        .err_pulse  (err_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          rl_cnt   = 0;
    logic [15:0] sb_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    function automatic logic [31:0] mk(input logic [1:0] t, input logic [7:0] d,
                                       input int i, input int v);
        return {1'b0, t, d, 8'(i), 13'(v)};
    endfunction

    task automatic push_exp(input int i, input int v);
        sb_q.push_back({3'(i), 13'(v)});
    endtask

    // Drives one packet from posedge+1 and returns at posedge+1 after its handshake.
    task automatic send(input logic [1:0] t, input logic [7:0] d, input int i, input int v);
        int n;
        n = 0;
        pkt_data  = mk(t, d, i, v);
        pkt_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (pkt_ready) begin
                @(posedge clk);
                #1;
                pkt_valid = 1'b0;
                $display("pkt  type=%0d dst=%0h idx=%0d data=%0d", t, d, i, v);
                return;
            end
            n++;
            if (n > 200) begin
                n_checks++;
                n_fail++;
                $display("FAIL send_timeout: pkt_ready never high, idx=%0d", i);
                pkt_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load_row(input int base, input int step);
        for (int i = 0; i < WF; i++) push_exp(i, base + i * step);
        for (int i = 0; i < WF; i++) send(2'b00, ADDR, i, base + i * step);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((sb_q.size() != 0 || w_valid) && n < 300);
        check(name, (n >= 300) ? 1 : 0, 0);
        if (n >= 300) sb_q.delete();
        @(posedge clk);
        #1;
    endtask

    // Monitor: weight handshakes, stall stability, pulse counting.
    logic          stall_prev = 1'b0;
    logic [2:0]    prev_idx;
    logic [WD-1:0] prev_data;
    logic [15:0]   exp_w;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && w_valid) begin
                check("stall_hold_data", int'(w_data), int'(prev_data));
                check("stall_hold_idx", int'(w_idx), int'(prev_idx));
            end
            if (w_valid && w_ready) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_weight: got idx=%0d data=%0d, expected none", w_idx, w_data);
                end else begin
                    exp_w = sb_q.pop_front();
                    check("w_idx", int'(w_idx), int'(exp_w[15:13]));
                    check("w_data", int'(w_data), int'(exp_w[12:0]));
                end
            end
            stall_prev = w_valid && !w_ready;
            prev_idx   = w_idx;
            prev_data  = w_data;
            if (row_loaded) rl_cnt++;
        end
    end

    int         rl_before;
    int         c;
    logic [3:0] pat;

    initial begin
        rst_n     = 1'b0;
        pkt_valid = 1'b0;
        pkt_data  = '0;
        w_ready   = 1'b1;
        pat       = 4'b1001;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_pkt_ready", pkt_ready, 0);
        check("rst_w_valid", w_valid, 0);
        check("rst_row_cnt", row_cnt, 0);
        check("rst_row_loaded", row_loaded, 0);
        check("rst_err_pulse", err_pulse, 0);
        check("rst_w_data", int'(w_data), 0);
        check("rst_w_idx", int'(w_idx), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("pkt_ready_after_rst", pkt_ready, 1);

        // In-order row, latency and single row_loaded pulse
        for (int i = 0; i < WF; i++) push_exp(i, 10 * (i + 1));
        for (int i = 0; i < WF; i++) send(2'b00, ADDR, i, 10 * (i + 1));
        check("latency_w_valid", w_valid, 1);
        check("row_loaded_pulse", row_loaded, 1);
        check("pkt_ready_drain", pkt_ready, 0);
        @(posedge clk);
        #1;
        check("row_loaded_one_cycle", row_loaded, 0);
        wait_idle("drain_row1");
        check("row_cnt_1", row_cnt, 1);
        check("row_loaded_count_1", rl_cnt, 1);

        // Out-of-order with duplicate overwrite of idx 1
        push_exp(0, 100); push_exp(1, 99); push_exp(2, 102); push_exp(3, 103); push_exp(4, 104);
        send(2'b00, ADDR, 3, 103);
        send(2'b00, ADDR, 1, 101);
        send(2'b00, ADDR, 4, 104);
        send(2'b00, ADDR, 0, 100);
        send(2'b00, ADDR, 1, 99);
        check("no_drain_before_full", w_valid, 0);
        send(2'b00, ADDR, 2, 102);
        wait_idle("drain_row2");
        check("row_cnt_2", row_cnt, 2);

        // Bad packets: wrong dst, wrong type, out-of-range idx
        send(2'b00, 8'(ADDR + 8'd1), 0, 7);
        check("err_bad_dst", err_pulse, EXP_ERR);
        send(2'b01, ADDR, 1, 8);
        check("err_bad_type", err_pulse, EXP_ERR);
        send(2'b00, ADDR, 7, 9);
        check("err_bad_idx", err_pulse, EXP_ERR);
        @(posedge clk);
        #1;
        check("err_one_cycle", err_pulse, 0);
        rl_before = rl_cnt;
`ifdef PE_FILTER_RX_PKT_CHECK_EN
        send(2'b00, ADDR, 2, 302);
        send(2'b00, ADDR, 3, 303);
        send(2'b00, ADDR, 4, 304);
        repeat (3) @(negedge clk);
        check("mask_unchanged_no_drain", w_valid, 0);
        check("mask_unchanged_no_row_loaded", rl_cnt, rl_before);
        @(posedge clk);
        #1;
        push_exp(0, 300); push_exp(1, 301); push_exp(2, 302); push_exp(3, 303); push_exp(4, 304);
        send(2'b00, ADDR, 0, 300);
        send(2'b00, ADDR, 1, 301);
`else
        push_exp(0, 7); push_exp(1, 8); push_exp(2, 302); push_exp(3, 303); push_exp(4, 304);
        send(2'b00, ADDR, 2, 302);
        send(2'b00, ADDR, 3, 303);
        send(2'b00, ADDR, 4, 304);
`endif
        wait_idle("drain_row3");
        check("row_cnt_3", row_cnt, 3);
        check("row_loaded_count_3", rl_cnt, rl_before + 1);

        // Back-pressure on the weight port with pkt_valid held high
        w_ready = 1'b0;
        load_row(200, 1);
        pkt_data  = mk(2'b00, ADDR, 7, 0);
        pkt_valid = 1'b1;
        c = 0;
        while (sb_q.size() != 0 && c < 100) begin
            w_ready = pat[c % 4];
            if (sb_q.size() == 1) pkt_valid = 1'b0;
            @(negedge clk);
            if (w_valid) check("pkt_ready_low_drain", pkt_ready, 0);
            @(posedge clk);
            #1;
            c++;
        end
        pkt_valid = 1'b0;
        w_ready   = 1'b1;
        wait_idle("drain_row4");
        check("row_cnt_4", row_cnt, 4);

        // Reset mid-load discards the partial row
        rl_before = rl_cnt;
        send(2'b00, ADDR, 0, 1);
        send(2'b00, ADDR, 1, 2);
        send(2'b00, ADDR, 2, 3);
        rst_n = 1'b0;
        @(negedge clk);
        check("pkt_ready_in_rst", pkt_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("row_cnt_after_midrst", row_cnt, 0);
        @(posedge clk);
        #1;
        load_row(60, 1);
        wait_idle("drain_after_rst");
        check("row_cnt_after_rst_row", row_cnt, 1);
        check("row_loaded_after_rst", rl_cnt, rl_before + 1);

        // 255 more rows: counter wraps to 0
        for (int r = 0; r < 255; r++) begin
            if (r == 254) check("row_cnt_255", row_cnt, 255);
            load_row(r * 5, 3);
            wait_idle("drain_wrap");
        end
        check("row_cnt_wrap", row_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

endmodule
